sram_axi_bridge: RTL and testbench

- Responder end of the CPU-side cache request interface (`inst_ren`/`inst_valid`, `data_ren`/`data_wen`/`data_valid`, `is_cache`).
- Accepts one instruction or data request at a time and converts it into a single-beat AXI read or write on the SoC bus.
- Returns the result as a one-cycle valid pulse with read data.
- Sits between the CPU request interface block and the AXI interconnect; a cache can later be inserted behind the same ports.

---
 rtl/sram_axi_bridge.sv | 200 ++++++++++++++++++++
 tb/tb_sram_axi_bridge.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_axi_bridge.sv
// sram_axi_bridge
//   Turns one CPU-side instruction or data request at a time into a single-beat
//   AXI read or write. The result comes back as a one-cycle valid pulse.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   inst_*            instruction fetch request / response
//   data_*            data read/write request / response
//   is_cache          1 = cacheable access (drives ar/awcache = 4'b1111)
//   ar*, r*           AXI read address / read data channels
//   aw*, w*, b*       AXI write address / write data / write response channels
module sram_axi_bridge #(
    parameter int unsigned      ID_W    = 4,
    parameter logic [ID_W-1:0]  INST_ID = '0,
    parameter logic [ID_W-1:0]  DATA_ID = ID_W'(1)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [31:0]     inst_addr,
    input  logic            inst_ren,
    output logic            inst_valid,
    output logic [31:0]     inst_rd,
    input  logic [31:0]     data_addr,
    input  logic            data_ren,
    input  logic [3:0]      data_wen,
    input  logic [31:0]     data_wd,
    output logic            data_valid,
    output logic [31:0]     data_rd,
    input  logic            is_cache,
    output logic [ID_W-1:0] arid,
    output logic [31:0]     araddr,
    output logic [7:0]      arlen,
    output logic [2:0]      arsize,
    output logic [1:0]      arburst,
    output logic [1:0]      arlock,
    output logic [3:0]      arcache,
    output logic [2:0]      arprot,
    output logic            arvalid,
    input  logic            arready,
    input  logic [ID_W-1:0] rid,
    input  logic [31:0]     rdata,
    input  logic [1:0]      rresp,
    input  logic            rlast,
    input  logic            rvalid,
    output logic            rready,
    output logic [ID_W-1:0] awid,
    output logic [31:0]     awaddr,
    output logic [7:0]      awlen,
    output logic [2:0]      awsize,
    output logic [1:0]      awburst,
    output logic [1:0]      awlock,
    output logic [3:0]      awcache,
    output logic [2:0]      awprot,
    output logic            awvalid,
    input  logic            awready,
    output logic [ID_W-1:0] wid,
    output logic [31:0]     wdata,
    output logic [3:0]      wstrb,
    output logic            wlast,
    output logic            wvalid,
    input  logic            wready,
    input  logic [ID_W-1:0] bid,
    input  logic [1:0]      bresp,
    input  logic            bvalid,
    output logic            bready
);

    typedef enum logic [2:0] {IDLE, RD_AR, RD_R, WR_AW_W, WR_B, RESP} state_t;

    state_t      state, state_nxt;
    logic [31:0] addr_r;
    logic [3:0]  wen_r;
    logic [31:0] wd_r;
    logic        cache_r;
    logic        is_data_r;
    logic        aw_done, w_done;
    logic        req_wr;

    // Response IDs/codes and rlast are not needed: one beat, errors ignored.
    logic unused_ok;
    assign unused_ok = ^{rid, rresp, rlast, bid, bresp};

    assign req_wr = |data_wen;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (req_wr)                    state_nxt = WR_AW_W;
                else if (data_ren || inst_ren) state_nxt = RD_AR;
            end
            RD_AR:   if (arready) state_nxt = RD_R;
            RD_R:    if (rvalid)  state_nxt = RESP;
            // A channel counts as finished if it already handshook or does so now.
            WR_AW_W: if ((aw_done || awready) && (w_done || wready)) state_nxt = WR_B;
            WR_B:    if (bvalid)  state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Request latch, per-channel write tracking and read-data capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_r    <= '0;
            wen_r     <= '0;
            wd_r      <= '0;
            cache_r   <= 1'b0;
            is_data_r <= 1'b0;
            aw_done   <= 1'b0;
            w_done    <= 1'b0;
            inst_rd   <= '0;
            data_rd   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    aw_done <= 1'b0;
                    w_done  <= 1'b0;
                    if (req_wr) begin
                        addr_r    <= data_addr;
                        wen_r     <= data_wen;
                        wd_r      <= data_wd;
                        cache_r   <= is_cache;
                        is_data_r <= 1'b1;
                    end else if (data_ren) begin
                        addr_r    <= data_addr;
                        wen_r     <= '0;
                        cache_r   <= is_cache;
                        is_data_r <= 1'b1;
                    end else if (inst_ren) begin
                        addr_r    <= inst_addr;
                        wen_r     <= '0;
                        cache_r   <= is_cache;
                        is_data_r <= 1'b0;
                    end
                end
                WR_AW_W: begin
                    if (awvalid && awready) aw_done <= 1'b1;
                    if (wvalid && wready)   w_done  <= 1'b1;
                end
                RD_R: begin
                    if (rvalid) begin
                        if (is_data_r) data_rd <= rdata;
                        else           inst_rd <= rdata;
                    end
                end
                default: ;
            endcase
        end
    end

    // AXI and CPU outputs decode from state; everything idles at zero.
    always_comb begin
        arid = '0; araddr = '0; arlen = '0; arsize = '0; arburst = '0;
        arlock = '0; arcache = '0; arprot = '0; arvalid = 1'b0;
        rready = 1'b0;
        awid = '0; awaddr = '0; awlen = '0; awsize = '0; awburst = '0;
        awlock = '0; awcache = '0; awprot = '0; awvalid = 1'b0;
        wid = '0; wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0;
        bready = 1'b0;
        inst_valid = 1'b0;
        data_valid = 1'b0;
        case (state)
            RD_AR: begin
                arvalid = 1'b1;
                arid    = is_data_r ? DATA_ID : INST_ID;
                araddr  = addr_r;
                arsize  = 3'd2;
                arburst = 2'b01;
                arcache = cache_r ? 4'b1111 : 4'b0000;
            end
            RD_R: rready = 1'b1;
            WR_AW_W: begin
                awvalid = !aw_done;
                awid    = DATA_ID;
                awaddr  = {addr_r[31:2], 2'b00};
                awsize  = 3'd2;
                awburst = 2'b01;
                awcache = cache_r ? 4'b1111 : 4'b0000;
                wvalid  = !w_done;
                wid     = DATA_ID;
                wdata   = wd_r;
                wstrb   = wen_r;
                wlast   = 1'b1;
            end
            WR_B: bready = 1'b1;
            RESP: begin
                inst_valid = !is_data_r;
                data_valid = is_data_r;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_sram_axi_bridge.sv
// Directed bench for sram_axi_bridge: the bench plays both the CPU requester
// and the AXI responder, stepping one clock at a time.
module tb_sram_axi_bridge;

    localparam int ID_W = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic [31:0]     inst_addr, data_addr, data_wd, rdata;
    logic            inst_ren, data_ren, is_cache;
    logic [3:0]      data_wen;
    logic            inst_valid, data_valid;
    logic [31:0]     inst_rd, data_rd;
    logic [ID_W-1:0] arid, rid, awid, wid, bid;
    logic [31:0]     araddr, awaddr, wdata;
    logic [7:0]      arlen, awlen;
    logic [2:0]      arsize, arprot, awsize, awprot;
    logic [1:0]      arburst, arlock, awburst, awlock, rresp, bresp;
    logic [3:0]      arcache, awcache, wstrb;
    logic            arvalid, arready, rlast, rvalid, rready;
    logic            awvalid, awready, wlast, wvalid, wready, bvalid, bready;

    int n_chk  = 0;
    int n_fail = 0;
    int ar_cnt = 0, aw_cnt = 0, iv_cnt = 0, dv_cnt = 0;
    logic [31:0] last_araddr = '0;
    bit ok;

    sram_axi_bridge #(.ID_W(ID_W), .INST_ID(4'd0), .DATA_ID(4'd1)) dut (
        .clk(clk), .rst(rst),
        .inst_addr(inst_addr), .inst_ren(inst_ren), .inst_valid(inst_valid), .inst_rd(inst_rd),
        .data_addr(data_addr), .data_ren(data_ren), .data_wen(data_wen), .data_wd(data_wd),
        .data_valid(data_valid), .data_rd(data_rd), .is_cache(is_cache),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
        .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    always #5 clk = ~clk;

    // Handshake and pulse counters seen at each active edge.
    always @(posedge clk) begin
        if (arvalid && arready) begin
            ar_cnt      <= ar_cnt + 1;
            last_araddr <= araddr;
        end
        if (awvalid && awready) aw_cnt <= aw_cnt + 1;
        if (inst_valid)         iv_cnt <= iv_cnt + 1;
        if (data_valid)         dv_cnt <= dv_cnt + 1;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_inst_valid(output bit found);
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (inst_valid) begin found = 1'b1; return; end
            step();
        end
    endtask

    task automatic wait_data_valid(output bit found);
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (data_valid) begin found = 1'b1; return; end
            step();
        end
    endtask

    initial begin
        rst = 1'b1;
        inst_addr = '0; inst_ren = 1'b0; data_addr = '0; data_ren = 1'b0;
        data_wen = '0; data_wd = '0; is_cache = 1'b0;
        arready = 1'b0; rid = '0; rdata = '0; rresp = '0; rlast = 1'b1; rvalid = 1'b0;
        awready = 1'b0; wready = 1'b0; bid = 4'd1; bresp = '0; bvalid = 1'b0;
        step(); step();

        // Reset values
        chk("rst_arvalid",    32'(arvalid),    32'd0);
        chk("rst_awvalid",    32'(awvalid),    32'd0);
        chk("rst_wvalid",     32'(wvalid),     32'd0);
        chk("rst_rready",     32'(rready),     32'd0);
        chk("rst_bready",     32'(bready),     32'd0);
        chk("rst_inst_valid", 32'(inst_valid), 32'd0);
        chk("rst_data_valid", 32'(data_valid), 32'd0);
        chk("rst_inst_rd",    inst_rd,         32'd0);
        chk("rst_data_rd",    data_rd,         32'd0);
        chk("rst_araddr",     araddr,          32'd0);
        rst = 1'b0;

        // Instruction fetch, zero-wait responder
        inst_ren = 1'b1; inst_addr = 32'h1FC0_0000; is_cache = 1'b0;
        arready = 1'b1; rvalid = 1'b1; rdata = 32'h3C1D_BFC0;
        step();
        chk("if_arvalid", 32'(arvalid), 32'd1);
        chk("if_araddr",  araddr,       32'h1FC0_0000);
        chk("if_arcache", 32'(arcache), 32'd0);
        chk("if_arid",    32'(arid),    32'd0);
        chk("if_arsize",  32'(arsize),  32'd2);
        chk("if_arlen",   32'(arlen),   32'd0);
        chk("if_arburst", 32'(arburst), 32'd1);
        step();
        chk("if_rready",  32'(rready),  32'd1);
        chk("if_ar_drop", 32'(arvalid), 32'd0);
        step();
        chk("if_inst_valid", 32'(inst_valid), 32'd1);
        chk("if_inst_rd",    inst_rd,         32'h3C1D_BFC0);
        chk("if_data_valid", 32'(data_valid), 32'd0);
        inst_ren = 1'b0; rvalid = 1'b0;
        step();
        chk("if_pulse_end", 32'(inst_valid), 32'd0);

        // Priority: write beats data read beats instruction read
        inst_ren = 1'b1; inst_addr = 32'h0000_0100;
        data_ren = 1'b1; data_addr = 32'h0000_1000; data_wen = 4'b0011; data_wd = 32'hA5A5_1234;
        awready = 1'b1; wready = 1'b1; bvalid = 1'b0;
        arready = 1'b1; rvalid = 1'b1; rdata = 32'h1111_2222;
        step();
        chk("pr_awvalid", 32'(awvalid), 32'd1);
        chk("pr_wvalid",  32'(wvalid),  32'd1);
        chk("pr_arvalid", 32'(arvalid), 32'd0);
        chk("pr_awaddr",  awaddr,       32'h0000_1000);
        chk("pr_wstrb",   32'(wstrb),   32'h3);
        chk("pr_wdata",   wdata,        32'hA5A5_1234);
        chk("pr_wlast",   32'(wlast),   32'd1);
        chk("pr_awid",    32'(awid),    32'd1);
        step();
        chk("pr_bready",  32'(bready),  32'd1);
        chk("pr_aw_drop", 32'(awvalid), 32'd0);
        chk("pr_w_drop",  32'(wvalid),  32'd0);
        bvalid = 1'b1;
        step();
        chk("pr_data_valid", 32'(data_valid), 32'd1);
        chk("pr_inst_quiet", 32'(inst_valid), 32'd0);
        data_ren = 1'b0; data_wen = 4'b0000; bvalid = 1'b0;
        step();
        chk("pr_idle_dv", 32'(data_valid), 32'd0);
        step();
        chk("pr_inst_ar",     32'(arvalid), 32'd1);
        chk("pr_inst_araddr", araddr,       32'h0000_0100);
        chk("pr_inst_arid",   32'(arid),    32'd0);
        step();
        step();
        chk("pr_inst_valid", 32'(inst_valid), 32'd1);
        chk("pr_inst_rd",    inst_rd,         32'h1111_2222);
        chk("pr_data_rd_hold", data_rd,       32'd0);
        inst_ren = 1'b0; rvalid = 1'b0;
        step();

        // Write channel skew: AW accepted at once, W three cycles late, B two more
        data_wen = 4'b1111; data_addr = 32'h0000_2006; data_wd = 32'hCAFE_F00D; is_cache = 1'b1;
        awready = 1'b1; wready = 1'b0; bvalid = 1'b0;
        step();
        chk("sk_c1_awvalid", 32'(awvalid), 32'd1);
        chk("sk_c1_wvalid",  32'(wvalid),  32'd1);
        chk("sk_awaddr",     awaddr,       32'h0000_2004);
        chk("sk_awcache",    32'(awcache), 32'hF);
        step();
        chk("sk_c2_awvalid", 32'(awvalid), 32'd0);
        chk("sk_c2_wvalid",  32'(wvalid),  32'd1);
        step();
        chk("sk_c3_awvalid", 32'(awvalid), 32'd0);
        chk("sk_c3_wvalid",  32'(wvalid),  32'd1);
        wready = 1'b1;
        step();
        chk("sk_b_wvalid", 32'(wvalid), 32'd0);
        chk("sk_b_bready", 32'(bready), 32'd1);
        wready = 1'b0;
        step();
        chk("sk_b_wait1", 32'(data_valid), 32'd0);
        step();
        chk("sk_b_wait2", 32'(bready), 32'd1);
        bvalid = 1'b1;
        step();
        chk("sk_data_valid", 32'(data_valid), 32'd1);
        data_wen = 4'b0000; bvalid = 1'b0; is_cache = 1'b0;
        step();
        chk("sk_pulse_end", 32'(data_valid), 32'd0);
        chk("sk_aw_count",  32'(aw_cnt),     32'd2);

        // Read backpressure with an error response
        data_ren = 1'b1; data_addr = 32'h0000_3000; arready = 1'b0; rvalid = 1'b0;
        step();
        for (int i = 0; i < 5; i++) begin
            chk("bp_arvalid", 32'(arvalid), 32'd1);
            chk("bp_araddr",  araddr,       32'h0000_3000);
            step();
        end
        arready = 1'b1;
        step();
        arready = 1'b0; rvalid = 1'b1; rdata = 32'hDEAD_BEEF; rresp = 2'b10;
        step();
        chk("bp_data_valid", 32'(data_valid), 32'd1);
        chk("bp_data_rd",    data_rd,         32'hDEAD_BEEF);
        chk("bp_inst_rd_hold", inst_rd,       32'h1111_2222);
        data_ren = 1'b0; rvalid = 1'b0; rresp = 2'b00;
        step();
        chk("bp_pulse_end", 32'(data_valid), 32'd0);

        // Back-to-back fetches, address changes in the cycle after each pulse
        inst_ren = 1'b1; inst_addr = 32'h0000_0400; rdata = 32'h0000_00A0;
        arready = 1'b1; rvalid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            wait_inst_valid(ok);
            chk("b2b_timeout", 32'(ok),     32'd1);
            chk("b2b_inst_rd", inst_rd,     32'h0000_00A0 + 32'(k));
            chk("b2b_araddr",  last_araddr, 32'h0000_0400 + 32'(4 * k));
            step();
            if (k < 2) begin
                inst_addr = 32'h0000_0400 + 32'(4 * (k + 1));
                rdata     = 32'h0000_00A0 + 32'(k + 1);
            end else begin
                inst_ren = 1'b0;
            end
        end
        rvalid = 1'b0;
        step();
        chk("b2b_ar_count", 32'(ar_cnt), 32'd6);
        chk("b2b_iv_count", 32'(iv_cnt), 32'd5);

        // Reset while waiting for read data
        data_ren = 1'b1; data_addr = 32'h0000_5000; arready = 1'b1; rvalid = 1'b0;
        step();
        step();
        chk("mr_rready", 32'(rready), 32'd1);
        rst = 1'b1;
        step();
        chk("mr_rready_rst",  32'(rready),     32'd0);
        chk("mr_arvalid_rst", 32'(arvalid),    32'd0);
        chk("mr_dv_rst",      32'(data_valid), 32'd0);
        chk("mr_inst_rd_rst", inst_rd,         32'd0);
        chk("mr_data_rd_rst", data_rd,         32'd0);
        rst = 1'b0; rvalid = 1'b1; rdata = 32'h7766_5544;
        step();
        wait_data_valid(ok);
        chk("mr_timeout", 32'(ok),  32'd1);
        chk("mr_data_rd", data_rd,  32'h7766_5544);
        data_ren = 1'b0; rvalid = 1'b0;
        step();
        chk("mr_ar_count", 32'(ar_cnt), 32'd8);
        chk("mr_dv_count", 32'(dv_cnt), 32'd4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "bench timeout");
    end

endmodule
